// File: rtl/liang_lsu.sv
// Load/store unit for the liang in-order core: one memory uop in flight, word-wide bus,
// byte/half/word loads with sign/zero extension and byte-lane stores.
module liang_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_load_type,
  input  logic [2:0]              in_store_type,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_rdata,
  output logic                    out_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  input  logic                    mem_rsp_err
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LH   = 3'd2,
    LOAD_LW   = 3'd3,
    LOAD_LD   = 3'd4,
    LOAD_LBU  = 3'd5,
    LOAD_LHU  = 3'd6,
    LOAD_LWU  = 3'd7
  } load_type_e;

  typedef enum logic [2:0] {
    STORE_NONE = 3'd0,
    STORE_SB   = 3'd1,
    STORE_SH   = 3'd2,
    STORE_SW   = 3'd3,
    STORE_SD   = 3'd4
  } store_type_e;

  state_e                state;
  logic [2:0]            ld_type_q;
  logic [1:0]            off_q;

  logic                  is_load;
  logic                  is_store;
  logic                  acc_legal;
  logic                  acc_bypass;
  logic                  acc_we;
  logic [STRB_WIDTH-1:0] acc_strb;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_ext;

  assign in_ready      = (state == S_IDLE) && !reset;
  assign mem_req_valid = (state == S_REQ);
  assign mem_rsp_ready = (state == S_RSP);
  assign out_valid     = (state == S_DONE);

  assign is_load  = (in_load_type != LOAD_NONE);
  assign is_store = (in_store_type != STORE_NONE);

  // Decode legality and store lane shaping straight from the offered uop.
  always_comb begin
    acc_legal  = 1'b0;
    acc_bypass = 1'b0;
    acc_we     = 1'b0;
    acc_strb   = '0;
    acc_wdata  = '0;
    if (!is_load && !is_store) begin
      acc_bypass = 1'b1;
    end else if (is_load && !is_store) begin
      case (in_load_type)
        LOAD_LB, LOAD_LBU: acc_legal = 1'b1;
        LOAD_LH, LOAD_LHU: acc_legal = !in_addr[0];
        LOAD_LW:           acc_legal = (in_addr[1:0] == 2'b00);
        default:           acc_legal = 1'b0;
      endcase
    end else if (!is_load && is_store) begin
      acc_we = 1'b1;
      case (in_store_type)
        STORE_SB: begin
          acc_legal = 1'b1;
          acc_strb  = STRB_WIDTH'(1) << in_addr[1:0];
          acc_wdata = {STRB_WIDTH{in_wdata[7:0]}};
        end
        STORE_SH: begin
          acc_legal = !in_addr[0];
          acc_strb  = STRB_WIDTH'(3) << in_addr[1:0];
          acc_wdata = {(STRB_WIDTH/2){in_wdata[15:0]}};
        end
        STORE_SW: begin
          acc_legal = (in_addr[1:0] == 2'b00);
          acc_strb  = '1;
          acc_wdata = in_wdata;
        end
        default: acc_legal = 1'b0;
      endcase
    end
  end

  // Load extension uses the captured type/offset; stores fall through to zero.
  always_comb begin
    lane     = mem_rsp_rdata >> {off_q, 3'b000};
    load_ext = '0;
    case (ld_type_q)
      LOAD_LB:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      LOAD_LBU: load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      LOAD_LH:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      LOAD_LHU: load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      LOAD_LW:  load_ext = lane;
      default:  load_ext = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      ld_type_q     <= '0;
      off_q         <= '0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      out_rdata     <= '0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            ld_type_q <= in_load_type;
            off_q     <= in_addr[1:0];
            if (acc_legal) begin
              mem_req_we    <= acc_we;
              mem_req_addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_req_wdata <= acc_wdata;
              mem_req_wstrb <= acc_strb;
              state         <= S_REQ;
            end else begin
              out_rdata <= '0;
              out_err   <= !acc_bypass;
              state     <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_RSP;
        end
        S_RSP: begin
          if (mem_rsp_valid) begin
            out_err   <= mem_rsp_err;
            out_rdata <= mem_rsp_err ? '0 : load_ext;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_liang_lsu.sv
// Self-checking bench for liang_lsu: directed cases plus randomized uops against an
// arithmetic reference model, with a bench-driven bus and WB consumer.
module tb_liang_lsu;

  localparam logic [2:0] LB = 3'd1, LH = 3'd2, LW = 3'd3, LD = 3'd4,
                         LBU = 3'd5, LHU = 3'd6, LWU = 3'd7;
  localparam logic [2:0] SB = 3'd1, SH = 3'd2, SW = 3'd3, SD = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_load_type;
  logic [2:0]  in_store_type;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clock = ~clock;

  liang_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load_type(in_load_type), .in_store_type(in_store_type),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: which accesses reach the bus and how a store is laid out.
  task automatic model_req(input logic [2:0] lt, input logic [2:0] st,
                           input logic [31:0] a, input logic [31:0] d,
                           output bit bus, output bit bypass, output bit we,
                           output logic [3:0] strb, output logic [31:0] wd);
    int unsigned off;
    off    = a % 4;
    bypass = (lt == 0) && (st == 0);
    bus    = 0;
    we     = (st != 0);
    strb   = 4'd0;
    wd     = 32'd0;
    if (lt != 0 && st == 0) begin
      if (lt == LB || lt == LBU) bus = 1;
      else if (lt == LH || lt == LHU) bus = (off % 2 == 0);
      else if (lt == LW) bus = (off == 0);
    end else if (lt == 0 && st != 0) begin
      if (st == SB) begin
        bus = 1; strb = 4'(1 << off); wd = (d & 32'hFF) * 32'h0101_0101;
      end else if (st == SH) begin
        bus = (off % 2 == 0); strb = 4'(3 << off); wd = (d & 32'hFFFF) * 32'h0001_0001;
      end else if (st == SW) begin
        bus = (off == 0); strb = 4'hF; wd = d;
      end
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] sh, b, h;
    sh = rd >> (8 * (a % 4));
    b  = sh % 256;
    h  = sh % 65536;
    case (lt)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      LW:      return rd;
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_uop(input logic [2:0] lt, input logic [2:0] st,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input bit rerr,
                         input int unsigned rw, input int unsigned pw, input int unsigned ow);
    bit bus, bypass, we;
    logic [3:0]  strb;
    logic [31:0] wd, exp_rdata;
    bit exp_err;
    model_req(lt, st, a, d, bus, bypass, we, strb, wd);
    if (!bus) begin
      exp_rdata = 0; exp_err = !bypass;
    end else if (rerr) begin
      exp_rdata = 0; exp_err = 1;
    end else begin
      exp_rdata = (st == 0) ? model_load(lt, a, rd) : 32'd0; exp_err = 0;
    end

    @(negedge clock);
    in_valid = 1; in_load_type = lt; in_store_type = st; in_addr = a; in_wdata = d;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 0; in_addr = $urandom; in_wdata = $urandom;

    if (bus) begin
      for (int unsigned w = 0; w <= rw; w++) begin
        @(negedge clock);
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_we", 32'(mem_req_we), 32'(we));
        check("req_addr", mem_req_addr, a & 32'hFFFF_FFFC);
        check("req_wstrb", 32'(mem_req_wstrb), 32'(strb));
        if (we) check("req_wdata", mem_req_wdata, wd);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        check("req_out_valid", 32'(out_valid), 32'd0);
        if (w == rw) mem_req_ready = 1;
        @(posedge clock); #1;
        mem_req_ready = 0;
      end
      for (int unsigned w = 0; w <= pw; w++) begin
        @(negedge clock);
        check("rsp_ready", 32'(mem_rsp_ready), 32'd1);
        check("rsp_req_valid", 32'(mem_req_valid), 32'd0);
        check("rsp_out_valid", 32'(out_valid), 32'd0);
        mem_rsp_rdata = (w == pw) ? rd : $urandom;
        mem_rsp_err   = (w == pw) ? rerr : 1'b0;
        if (w == pw) mem_rsp_valid = 1;
        @(posedge clock); #1;
        mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_rdata = $urandom;
      end
    end

    for (int unsigned w = 0; w <= ow; w++) begin
      @(negedge clock);
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_rdata", out_rdata, exp_rdata);
      check("out_err", 32'(out_err), 32'(exp_err));
      check("done_req_valid", 32'(mem_req_valid), 32'd0);
      check("done_in_ready", 32'(in_ready), 32'd0);
      if (w == ow) out_ready = 1;
      @(posedge clock); #1;
      out_ready = 0;
    end
    @(negedge clock);
    check("back_idle_out_valid", 32'(out_valid), 32'd0);
    check("back_idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_load_type = 0; in_store_type = 0; in_addr = 0; in_wdata = 0;
    out_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_rdata", out_rdata, 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_req_wdata", mem_req_wdata, 32'd0);
    check("rst_req_wstrb", 32'(mem_req_wstrb), 32'd0);
    check("rst_req_we", 32'(mem_req_we), 32'd0);
    reset = 0;

    // Directed cases.
    run_uop(LB,  0,  32'h8000_0003, 32'h0, 32'h80AA_BBCC, 0, 0, 0, 0);
    run_uop(LHU, 0,  32'h8000_0002, 32'h0, 32'hBEEF_1234, 0, 0, 0, 0);
    run_uop(0,   SB, 32'h8000_0001, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 0, 0);
    run_uop(0,   SW, 32'h8000_0002, 32'h1111_2222, 32'h0, 0, 0, 0, 0);
    run_uop(0,   SD, 32'h8000_0000, 32'h1111_2222, 32'h0, 0, 0, 0, 0);
    run_uop(0,   0,  32'h8000_0000, 32'h1111_2222, 32'h0, 0, 0, 0, 0);
    run_uop(LD,  0,  32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    run_uop(LWU, 0,  32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    run_uop(LW,  SW, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    run_uop(LH,  0,  32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, 0);
    run_uop(LH,  0,  32'h8000_0002, 32'h0, 32'h8001_0000, 0, 0, 0, 0);
    run_uop(0,   SH, 32'h8000_0002, 32'hCAFE_F00D, 32'h0, 0, 3, 1, 2);
    run_uop(LW,  0,  32'h8000_0010, 32'h0, 32'h1234_5678, 1, 3, 0, 2);
    run_uop(0,   SW, 32'h8000_0014, 32'hA5A5_5A5A, 32'h0, 1, 0, 2, 0);

    // Reset while a load waits for its response.
    @(negedge clock);
    in_valid = 1; in_load_type = LW; in_store_type = 0; in_addr = 32'h8000_0020;
    @(posedge clock); #1; in_valid = 0;
    @(negedge clock); mem_req_ready = 1;
    @(posedge clock); #1; mem_req_ready = 0;
    @(negedge clock);
    check("mid_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    reset = 1;
    #1 check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1; reset = 0;
    @(negedge clock);
    check("post_rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_req_addr", mem_req_addr, 32'd0);
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h1234_5678;
    @(posedge clock); #1; mem_rsp_valid = 0;
    @(negedge clock);
    check("late_rsp_out_valid", 32'(out_valid), 32'd0);
    check("late_rsp_in_ready", 32'(in_ready), 32'd1);
    check("late_rsp_rdata", out_rdata, 32'd0);

    // Randomized uops.
    for (int i = 0; i < 200; i++) begin
      logic [2:0] lt, st;
      int unsigned mode;
      mode = $urandom_range(0, 9);
      lt = 0; st = 0;
      if (mode < 4) lt = 3'($urandom_range(1, 7));
      else if (mode < 8) st = 3'($urandom_range(1, 7));
      else if (mode == 8) begin
        lt = 3'($urandom_range(1, 7)); st = 3'($urandom_range(1, 7));
      end
      run_uop(lt, st, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom,
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
